mux_wb_ctrl: RTL

- Wishbone responder that drives the shared project-select interface from the management SoC: `sel`, `in`, `clk` and `rst_n` towards the input multiplexer.
- Samples `out` returned by the output multiplexer.
- Provides a register file plus a programmable project-clock generator: single-step N pulses, or free-run at a divided rate.
- Gives firmware full control of any selected project without using the IO pads.

---
 rtl/mux_wb_ctrl_pkg.sv | 28 ++
 rtl/mux_wb_ctrl_proj_clk_gen.sv | 101 ++++++++++
 rtl/mux_wb_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_wb_ctrl_pkg.sv
// Shared constants for the project-select Wishbone controller: register offsets,
// CTRL/STEP field positions, the project-clock FSM states and the CTRL reset value.
package mux_wb_ctrl_pkg;

  localparam logic [4:0] REG_CTRL = 5'h00;
  localparam logic [4:0] REG_IN   = 5'h04;
  localparam logic [4:0] REG_OUT  = 5'h08;
  localparam logic [4:0] REG_STEP = 5'h0C;
  localparam logic [4:0] REG_DIV  = 5'h10;

  localparam int CTRL_PRST    = 0;
  localparam int CTRL_FREERUN = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int CTRL_SEL     = 8;

  localparam int STEP_BUSY    = 16;
  localparam int STEP_OVERRUN = 17;
  localparam int STEP_DONE    = 18;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  typedef enum logic [1:0] {
    CLK_IDLE = 2'd0,
    CLK_HIGH = 2'd1,
    CLK_LOW  = 2'd2
  } clk_state_e;

endpackage

// File: rtl/mux_wb_ctrl_proj_clk_gen.sv
// Project clock generator: N single-step pulses or free-running clock, each
// phase lasting div+1 cycles, with the divider sampled at every phase boundary.
module proj_clk_gen
  import mux_wb_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic [15:0] n,
  input  logic        freerun,
  input  logic [7:0]  div,
  output logic        clk,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] remaining,
  output clk_state_e  state
);

  clk_state_e  state_q;
  logic        clk_q;
  logic        done_q;
  logic        stepping_q;
  logic [15:0] rem_q;
  logic [7:0]  cnt_q;
  logic [7:0]  div_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CLK_IDLE;
      clk_q      <= 1'b0;
      done_q     <= 1'b0;
      stepping_q <= 1'b0;
      rem_q      <= 16'd0;
      cnt_q      <= 8'd0;
      div_q      <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CLK_IDLE: begin
          cnt_q <= 8'd0;
          div_q <= div;
          if (load && (n != 16'd0)) begin
            rem_q      <= n;
            stepping_q <= 1'b1;
            state_q    <= CLK_HIGH;
            clk_q      <= 1'b1;
          end else if (freerun) begin
            stepping_q <= 1'b0;
            state_q    <= CLK_HIGH;
            clk_q      <= 1'b1;
          end
        end
        CLK_HIGH: begin
          if (cnt_q == div_q) begin
            cnt_q   <= 8'd0;
            div_q   <= div;
            state_q <= CLK_LOW;
            clk_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CLK_LOW: begin
          if (cnt_q == div_q) begin
            cnt_q <= 8'd0;
            div_q <= div;
            if (stepping_q) begin
              rem_q <= rem_q - 16'd1;
              if (rem_q == 16'd1) begin
                state_q    <= CLK_IDLE;
                stepping_q <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                state_q <= CLK_HIGH;
                clk_q   <= 1'b1;
              end
            end else if (freerun) begin
              state_q <= CLK_HIGH;
              clk_q   <= 1'b1;
            end else begin
              state_q <= CLK_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= CLK_IDLE;
          clk_q   <= 1'b0;
        end
      endcase
    end
  end

  assign clk        = clk_q;
  assign busy       = stepping_q;
  assign done_pulse = done_q;
  assign remaining  = rem_q;
  assign state      = state_q;

endmodule

// File: rtl/mux_wb_ctrl.sv
// Wishbone responder driving the project-select mux (sel/in/clk/rst_n) and sampling out.
// Define MUX_WB_CTRL_IRQ_EN to add the irq output and the CTRL[2] IRQEN bit.
module mux_wb_ctrl
  import mux_wb_ctrl_pkg::*;
#(
  parameter int          SEL_BITS    = 2,
  parameter int          INPUT_BITS  = 16,
  parameter int          OUTPUT_BITS = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [SEL_BITS-1:0]    sel,
  output logic                   clk,
  output logic                   rst_n,
  output logic [INPUT_BITS-1:0]  in,
  input  logic [OUTPUT_BITS-1:0] out
`ifdef MUX_WB_CTRL_IRQ_EN
  ,
  output logic                   irq
`endif
);

  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;
  logic                   prst_q, prst_d;
  logic                   freerun_q, freerun_d;
  logic [SEL_BITS-1:0]    ctrl_sel_q, ctrl_sel_d;
  logic [INPUT_BITS-1:0]  in_reg_q, in_reg_d;
  logic [7:0]             div_q, div_d;
  logic [OUTPUT_BITS-1:0] out_q;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   load_q, load_d;
  logic [15:0]            step_n_q, step_n_d;
  logic [SEL_BITS-1:0]    sel_o_q;
  logic [INPUT_BITS-1:0]  in_o_q;
  logic                   rst_n_q;
`ifdef MUX_WB_CTRL_IRQ_EN
  logic                   irqen_q, irqen_d;
  logic                   irq_q;
`endif

  logic        gen_clk, gen_busy, gen_done;
  logic [15:0] gen_rem;
  clk_state_e  gen_state;

  logic        req, accept, wr, step_wr, flag_wr, step_cmd, active;
  logic [4:0]  offset;
  logic [15:0] step_n_wr;
  logic [31:0] ctrl_rd, step_rd, rdata;
  logic        unused_ok;

  // Valid/ready: a request is stb&cyc inside the window; it is accepted on the
  // edge where ack is low, ack is high for exactly the following cycle.
  assign req      = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign accept   = req && !ack_q;
  assign wr       = accept && wbs_we_i;
  assign offset   = {wbs_adr_i[4:2], 2'b00};
  assign step_wr  = wr && (offset == REG_STEP);
  assign step_n_wr = {wbs_sel_i[1] ? wbs_dat_i[15:8] : 8'h00,
                      wbs_sel_i[0] ? wbs_dat_i[7:0]  : 8'h00};
  // A STEP write carrying a flag-clear bit is flag maintenance, not a pulse command.
  assign flag_wr  = step_wr && wbs_sel_i[2] && (wbs_dat_i[STEP_OVERRUN] || wbs_dat_i[STEP_DONE]);
  assign step_cmd = step_wr && (wbs_sel_i[0] || wbs_sel_i[1]) && !flag_wr;
  assign active   = load_q || (gen_state != CLK_IDLE) || freerun_q;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_PRST]    = prst_q;
    ctrl_rd[CTRL_FREERUN] = freerun_q;
`ifdef MUX_WB_CTRL_IRQ_EN
    ctrl_rd[CTRL_IRQEN]   = irqen_q;
`endif
    ctrl_rd[CTRL_SEL +: SEL_BITS] = ctrl_sel_q;

    step_rd = '0;
    step_rd[15:0]         = gen_rem;
    step_rd[STEP_BUSY]    = gen_busy;
    step_rd[STEP_OVERRUN] = overrun_q;
    step_rd[STEP_DONE]    = done_q;

    case (offset)
      REG_CTRL: rdata = ctrl_rd;
      REG_IN:   rdata = 32'(in_reg_q);
      REG_OUT:  rdata = 32'(out_q);
      REG_STEP: rdata = step_rd;
      REG_DIV:  rdata = {24'h0, div_q};
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ack_d      = accept;
    dat_d      = accept ? rdata : 32'h0;
    prst_d     = prst_q;
    freerun_d  = freerun_q;
    ctrl_sel_d = ctrl_sel_q;
    in_reg_d   = in_reg_q;
    div_d      = div_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    load_d     = 1'b0;
    step_n_d   = step_n_q;
`ifdef MUX_WB_CTRL_IRQ_EN
    irqen_d    = irqen_q;
`endif

    if (wr && (offset == REG_CTRL)) begin
      if (wbs_sel_i[0]) begin
        prst_d    = wbs_dat_i[CTRL_PRST];
        freerun_d = wbs_dat_i[CTRL_FREERUN];
`ifdef MUX_WB_CTRL_IRQ_EN
        irqen_d   = wbs_dat_i[CTRL_IRQEN];
`endif
      end
      if (wbs_sel_i[1]) ctrl_sel_d = wbs_dat_i[CTRL_SEL +: SEL_BITS];
    end

    if (wr && (offset == REG_IN)) begin
      for (int i = 0; i < INPUT_BITS; i++) begin
        if (wbs_sel_i[i/8]) in_reg_d[i] = wbs_dat_i[i];
      end
    end

    if (wr && (offset == REG_DIV) && wbs_sel_i[0]) div_d = wbs_dat_i[7:0];

    if (flag_wr) begin
      if (wbs_dat_i[STEP_OVERRUN]) overrun_d = 1'b0;
      if (wbs_dat_i[STEP_DONE])    done_d    = 1'b0;
    end

    if (step_cmd) begin
      if (active) begin
        overrun_d = 1'b1;
      end else if (step_n_wr == 16'd0) begin
        done_d = 1'b1;
      end else begin
        load_d   = 1'b1;
        step_n_d = step_n_wr;
      end
    end

    if (gen_done) done_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      prst_q     <= CTRL_RESET[CTRL_PRST];
      freerun_q  <= 1'b0;
      ctrl_sel_q <= '0;
      in_reg_q   <= '0;
      div_q      <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      load_q     <= 1'b0;
      step_n_q   <= '0;
      sel_o_q    <= '0;
      in_o_q     <= '0;
      rst_n_q    <= 1'b0;
`ifdef MUX_WB_CTRL_IRQ_EN
      irqen_q    <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      prst_q     <= prst_d;
      freerun_q  <= freerun_d;
      ctrl_sel_q <= ctrl_sel_d;
      in_reg_q   <= in_reg_d;
      div_q      <= div_d;
      out_q      <= out;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      load_q     <= load_d;
      step_n_q   <= step_n_d;
      sel_o_q    <= ctrl_sel_q;
      in_o_q     <= in_reg_q;
      rst_n_q    <= !prst_q;
`ifdef MUX_WB_CTRL_IRQ_EN
      irqen_q    <= irqen_d;
      irq_q      <= done_q && irqen_q;
`endif
    end
  end

  proj_clk_gen u_clk_gen (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load       (load_q),
    .n          (step_n_q),
    .freerun    (freerun_q),
    .div        (div_q),
    .clk        (gen_clk),
    .busy       (gen_busy),
    .done_pulse (gen_done),
    .remaining  (gen_rem),
    .state      (gen_state)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign sel       = sel_o_q;
  assign in        = in_o_q;
  assign rst_n     = rst_n_q;
  assign clk       = gen_clk;
`ifdef MUX_WB_CTRL_IRQ_EN
  assign irq       = irq_q;
`endif

endmodule
